// File: rtl/char_box_locate.sv
// Per-frame character bounding-box finder: qualifies rows by in-window foreground count and
// latches the union box at the end of each frame for the downstream feature scanner.
module char_box_locate #(
    parameter int unsigned ROW_MIN = 3,
    parameter int unsigned MIN_W   = 8,
    parameter int unsigned MIN_H   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_th,
    input  logic [11:0] win_left,
    input  logic [11:0] win_right,
    input  logic [11:0] win_up,
    input  logic [11:0] win_down,
    output logic [11:0] char_up,
    output logic [11:0] char_down,
    output logic [11:0] char_left,
    output logic [11:0] char_right,
    output logic        box_valid,
    output logic        box_found,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y
);

    typedef enum logic [1:0] {StWaitVs, StActive, StEval} state_e;

    state_e      state_q, state_d;
    logic        de_d, vs_d;
    logic [11:0] row_cnt_q, row_cnt_d;
    logic [11:0] row_min_x_q, row_min_x_d;
    logic [11:0] row_max_x_q, row_max_x_d;
    logic [11:0] row_y_q, row_y_d;
    logic [11:0] top_q, top_d, bottom_q, bottom_d;
    logic [11:0] left_q, left_d, right_q, right_d;
    logic        found_q, found_d;
    logic [11:0] char_up_d, char_down_d, char_left_d, char_right_d;
    logic        box_valid_d, box_found_d;

    logic        in_win, hit, row_end, line_start, vs_rise, vs_fall, row_ok, accept;
    logic [12:0] height, width;

    assign in_win     = (i_x >= win_left) && (i_x <= win_right) &&
                        (i_y >= win_up) && (i_y <= win_down);
    assign hit        = i_de && i_vs && i_th && in_win;
    assign row_end    = de_d && !i_de;
    assign line_start = i_de && !de_d;
    assign vs_rise    = !vs_d && i_vs;
    assign vs_fall    = vs_d && !i_vs;
    assign row_ok     = 32'(row_cnt_q) >= ROW_MIN;

    assign height = {1'b0, bottom_q} - {1'b0, top_q} + 13'd1;
    assign width  = {1'b0, right_q} - {1'b0, left_q} + 13'd1;
    assign accept = found_q && (bottom_q >= top_q) && (right_q >= left_q) &&
                    (32'(height) >= MIN_H) && (32'(width) >= MIN_W);

    // Row accumulators run free; only frame commits are gated by the FSM.
    always_comb begin
        row_cnt_d   = row_cnt_q;
        row_min_x_d = row_min_x_q;
        row_max_x_d = row_max_x_q;
        row_y_d     = row_y_q;
        if (line_start) row_y_d = i_y;
        if (row_end) begin
            row_cnt_d   = 12'd0;
            row_min_x_d = 12'hFFF;
            row_max_x_d = 12'd0;
        end else if (hit) begin
            if (row_cnt_q != 12'hFFF) row_cnt_d = row_cnt_q + 12'd1;
            if (i_x < row_min_x_q) row_min_x_d = i_x;
            if (i_x > row_max_x_q) row_max_x_d = i_x;
        end
    end

    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        bottom_d     = bottom_q;
        left_d       = left_q;
        right_d      = right_q;
        found_d      = found_q;
        char_up_d    = char_up;
        char_down_d  = char_down;
        char_left_d  = char_left;
        char_right_d = char_right;
        box_valid_d  = 1'b0;
        box_found_d  = box_found;
        unique case (state_q)
            StWaitVs: begin
                top_d    = 12'hFFF;
                bottom_d = 12'd0;
                left_d   = 12'hFFF;
                right_d  = 12'd0;
                found_d  = 1'b0;
                if (vs_rise) state_d = StActive;
            end
            StActive: begin
                // A row end coinciding with the vs fall still commits before evaluation.
                if (row_end && row_ok) begin
                    if (row_y_q < top_q) top_d = row_y_q;
                    if (row_y_q > bottom_q) bottom_d = row_y_q;
                    if (row_min_x_q < left_q) left_d = row_min_x_q;
                    if (row_max_x_q > right_q) right_d = row_max_x_q;
                    found_d = 1'b1;
                end
                if (vs_fall) state_d = StEval;
            end
            StEval: begin
                if (accept) begin
                    char_up_d    = top_q;
                    char_down_d  = bottom_q;
                    char_left_d  = left_q;
                    char_right_d = right_q;
                    box_valid_d  = 1'b1;
                    box_found_d  = 1'b1;
                end else begin
                    box_found_d  = 1'b0;
                end
                top_d    = 12'hFFF;
                bottom_d = 12'd0;
                left_d   = 12'hFFF;
                right_d  = 12'd0;
                found_d  = 1'b0;
                state_d  = StWaitVs;
            end
            default: state_d = StWaitVs;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWaitVs;
            de_d        <= 1'b0;
            // Reset high so a reset released mid-frame does not look like a frame start.
            vs_d        <= 1'b1;
            row_cnt_q   <= 12'd0;
            row_min_x_q <= 12'hFFF;
            row_max_x_q <= 12'd0;
            row_y_q     <= 12'd0;
            top_q       <= 12'hFFF;
            bottom_q    <= 12'd0;
            left_q      <= 12'hFFF;
            right_q     <= 12'd0;
            found_q     <= 1'b0;
            char_up     <= 12'd0;
            char_down   <= 12'd0;
            char_left   <= 12'd0;
            char_right  <= 12'd0;
            box_valid   <= 1'b0;
            box_found   <= 1'b0;
            o_hs        <= 1'b0;
            o_vs        <= 1'b0;
            o_de        <= 1'b0;
            o_x         <= 12'd0;
            o_y         <= 12'd0;
        end else begin
            state_q     <= state_d;
            de_d        <= i_de;
            vs_d        <= i_vs;
            row_cnt_q   <= row_cnt_d;
            row_min_x_q <= row_min_x_d;
            row_max_x_q <= row_max_x_d;
            row_y_q     <= row_y_d;
            top_q       <= top_d;
            bottom_q    <= bottom_d;
            left_q      <= left_d;
            right_q     <= right_d;
            found_q     <= found_d;
            char_up     <= char_up_d;
            char_down   <= char_down_d;
            char_left   <= char_left_d;
            char_right  <= char_right_d;
            box_valid   <= box_valid_d;
            box_found   <= box_found_d;
            o_hs        <= i_hs;
            o_vs        <= i_vs;
            o_de        <= i_de;
            o_x         <= i_x;
            o_y         <= i_y;
        end
    end

endmodule
